// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// MULT runs an unsigned shift-add over n cycles, DIV a restoring divide over n cycles;
// MTHI/MTLO/MFHI/MFLO are serviced in IDLE without leaving it.
module muldiv_sequencer #(
    parameter int unsigned n = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [3:0]     req_f,
    input  logic [n-1:0]   req_a,
    input  logic [n-1:0]   req_b,
    output logic           rd_valid,
    output logic [n-1:0]   rd_data,
    output logic           done,
    output logic           div_by_zero,
    output logic           busy,
    output logic [2*n-1:0] out_2n
);

    localparam int unsigned CntW = $clog2(n + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [n-1:0]     r_hi, w_hi_nxt;
    logic [n-1:0]     r_lo, w_lo_nxt;
    logic [n-1:0]     r_rd_data, w_rd_data_nxt;
    logic             r_rd_valid, w_rd_valid_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic [CntW-1:0]  r_cnt, w_cnt_nxt;
    // Working accumulator: MULT keeps {partial high, remaining multiplier},
    // DIV keeps {remainder, dividend/quotient}. Either way it ends as {hi, lo}.
    logic [2*n-1:0]   r_acc, w_acc_nxt;
    // Multiplicand for MULT, divisor for DIV.
    logic [n-1:0]     r_opnd, w_opnd_nxt;

    logic [n:0]       w_mul_sum;
    logic [n:0]       w_div_shift;
    logic [n:0]       w_div_diff;
    logic             w_div_ge;
    logic [2*n-1:0]   w_mul_step;
    logic [2*n-1:0]   w_div_step;

    logic             w_unused;
    assign w_unused = req_f[2];

    // One shift-add or restoring-divide iteration on the working accumulator.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*n-1:n]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_step  = {w_mul_sum, r_acc[n-1:1]};
        w_div_shift = r_acc[2*n-1:n-1];
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        w_div_step  = {(w_div_ge ? w_div_diff[n-1:0] : w_div_shift[n-1:0]),
                       r_acc[n-2:0], w_div_ge};
    end

    // Next-state: command decode in IDLE, iteration in BUSY, single DONE cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_dbz_nxt      = r_dbz;
        w_is_div_nxt   = r_is_div;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_opnd_nxt     = r_opnd;
        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (req_f[3]) begin
                        w_is_div_nxt = ~req_f[1];
                        w_dbz_nxt    = 1'b0;
                        if (!req_f[1] && (req_b == '0)) begin
                            w_hi_nxt    = req_a;
                            w_lo_nxt    = '1;
                            w_dbz_nxt   = 1'b1;
                            w_state_nxt = StDone;
                        end else begin
                            w_acc_nxt   = req_f[1] ? {{n{1'b0}}, req_b} : {{n{1'b0}}, req_a};
                            w_opnd_nxt  = req_f[1] ? req_a : req_b;
                            w_cnt_nxt   = CntW'(n);
                            w_state_nxt = StBusy;
                        end
                    end else if (req_f[0]) begin
                        if (req_f[1]) begin
                            w_lo_nxt = req_a;
                        end else begin
                            w_hi_nxt = req_a;
                        end
                    end else begin
                        w_rd_data_nxt  = req_f[1] ? r_hi : r_lo;
                        w_rd_valid_nxt = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (r_cnt != '0) begin
                    w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
                    w_cnt_nxt = r_cnt - CntW'(1);
                end else begin
                    w_hi_nxt    = r_acc[2*n-1:n];
                    w_lo_nxt    = r_acc[n-1:0];
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_hi       <= '0;
            r_lo       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_dbz      <= 1'b0;
            r_is_div   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_dbz      <= w_dbz_nxt;
            r_is_div   <= w_is_div_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_opnd     <= w_opnd_nxt;
        end
    end

    assign req_ready   = (r_state == StIdle);
    assign busy        = (r_state == StBusy);
    assign done        = (r_state == StDone);
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign div_by_zero = r_dbz;
    assign out_2n      = {r_hi, r_lo};

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer (n = 4).
module tb_muldiv_sequencer;

    localparam int unsigned N = 4;

    localparam logic [3:0] F_MULT  = 4'b1010;
    localparam logic [3:0] F_MULT2 = 4'b1110;
    localparam logic [3:0] F_DIV   = 4'b1000;
    localparam logic [3:0] F_DIV2  = 4'b1100;
    localparam logic [3:0] F_MTHI  = 4'b0001;
    localparam logic [3:0] F_MTLO  = 4'b0011;
    localparam logic [3:0] F_MFHI  = 4'b0010;
    localparam logic [3:0] F_MFLO  = 4'b0000;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     req_f;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic           rd_valid;
    logic [N-1:0]   rd_data;
    logic           done;
    logic           div_by_zero;
    logic           busy;
    logic [2*N-1:0] out_2n;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_f       (req_f),
        .req_a       (req_a),
        .req_b       (req_b),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .done        (done),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .out_2n      (out_2n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] f;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_out;  // {hi, lo} after commit
        logic       exp_dbz;
        logic       rd_hi;    // read back HI (1) or LO (0) afterwards
    } vec_t;

    vec_t vecs [12];
    logic [7:0] model_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_arith(input int idx, input vec_t v, input logic [7:0] prev_out);
        int  k;
        int  done_k;
        int  n_done;
        int  n_busy;
        int  n_low;
        int  n_clobber;
        bit  zdiv;
        logic [7:0] out_at_done;
        logic       dbz_at_done;
        zdiv        = v.f[3] && !v.f[1] && (v.b == 4'd0);
        k           = 0;
        done_k      = -1;
        n_done      = 0;
        n_busy      = 0;
        n_low       = 0;
        n_clobber   = 0;
        out_at_done = 8'hxx;
        dbz_at_done = 1'bx;
        req_f     = v.f;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_a     = 4'($urandom);
        req_b     = 4'($urandom);
        while (req_ready !== 1'b1 && k < 20) begin
            if (done === 1'b1) begin
                n_done++;
                if (done_k < 0) begin
                    done_k      = k;
                    out_at_done = out_2n;
                    dbz_at_done = div_by_zero;
                end
            end
            if (busy === 1'b1) begin
                n_busy++;
                if (out_2n !== prev_out) n_clobber++;
            end
            n_low++;
            step();
            k++;
        end
        check($sformatf("v%0d ready_back", idx), 32'(req_ready), 32'd1);
        check($sformatf("v%0d done_latency", idx), done_k, zdiv ? 0 : N + 1);
        check($sformatf("v%0d stall_cycles", idx), n_low, zdiv ? 1 : N + 2);
        check($sformatf("v%0d busy_cycles", idx), n_busy, zdiv ? 0 : N + 1);
        check($sformatf("v%0d done_pulses", idx), n_done, 1);
        check($sformatf("v%0d hilo_held", idx), n_clobber, 0);
        check($sformatf("v%0d result", idx), 32'(out_at_done), 32'(v.exp_out));
        check($sformatf("v%0d dbz", idx), 32'(dbz_at_done), 32'(v.exp_dbz));
        check($sformatf("v%0d out_idle", idx), 32'(out_2n), 32'(v.exp_out));
    endtask

    task automatic do_read(input string name, input logic [3:0] f, input logic [3:0] exp);
        req_f     = f;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check({name, " rd_valid"}, 32'(rd_valid), 32'd1);
        check({name, " rd_data"}, 32'(rd_data), 32'(exp));
        check({name, " no_busy"}, 32'(busy | done), 32'd0);
        step();
        check({name, " rd_valid_drop"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   k;
        int   first_rd;
        int   n_rd;
        int   n_done;
        bit   go;
        logic [3:0] rd_seen;

        vecs[0]  = '{F_MULT,  4'd13, 4'd11, 8'h8F, 1'b0, 1'b0};
        vecs[1]  = '{F_DIV,   4'd13, 4'd4,  8'h13, 1'b0, 1'b0};
        vecs[2]  = '{F_DIV2,  4'd9,  4'd0,  8'h9F, 1'b1, 1'b1};
        vecs[3]  = '{F_MULT2, 4'd2,  4'd3,  8'h06, 1'b0, 1'b0};
        vecs[4]  = '{F_DIV,   4'd14, 4'd3,  8'h24, 1'b0, 1'b1};
        vecs[5]  = '{F_MULT,  4'd7,  4'd8,  8'h38, 1'b0, 1'b1};
        vecs[6]  = '{F_DIV,   4'd7,  4'd9,  8'h70, 1'b0, 1'b1};
        vecs[7]  = '{F_MULT,  4'd0,  4'd9,  8'h00, 1'b0, 1'b0};
        vecs[8]  = '{F_DIV2,  4'd15, 4'd1,  8'h0F, 1'b0, 1'b0};
        vecs[9]  = '{F_MULT,  4'd15, 4'd15, 8'hE1, 1'b0, 1'b1};
        vecs[10] = '{F_DIV,   4'd0,  4'd0,  8'h0F, 1'b1, 1'b0};
        vecs[11] = '{F_MULT,  4'd1,  4'd1,  8'h01, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_f     = 4'd0;
        req_a     = 4'd0;
        req_b     = 4'd0;
        #3;
        check("reset out_2n", 32'(out_2n), 32'd0);
        check("reset flags", 32'({rd_valid, done, div_by_zero, busy}), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset ready", 32'(req_ready), 32'd1);
        #9;
        rst_n = 1'b1;
        step();

        // Arithmetic table, each followed by a HI or LO read-back.
        model_out = 8'h00;
        for (int i = 0; i < 12; i++) begin
            run_arith(i, vecs[i], model_out);
            model_out = vecs[i].exp_out;
            do_read($sformatf("v%0d read", i), vecs[i].rd_hi ? F_MFHI : F_MFLO,
                    vecs[i].rd_hi ? model_out[7:4] : model_out[3:0]);
        end

        // MTHI, MTLO, then MFHI and MFLO back to back.
        req_valid = 1'b1;
        req_f = F_MTHI; req_a = 4'd5;
        step();
        check("mthi hi", 32'(out_2n), 32'h51);
        req_f = F_MTLO; req_a = 4'hA;
        step();
        check("mtlo lo", 32'(out_2n), 32'h5A);
        req_f = F_MFHI;
        step();
        check("b2b mfhi valid", 32'(rd_valid), 32'd1);
        check("b2b mfhi data", 32'(rd_data), 32'd5);
        req_f = F_MFLO;
        step();
        check("b2b mflo valid", 32'(rd_valid), 32'd1);
        check("b2b mflo data", 32'(rd_data), 32'hA);
        check("b2b no busy/done", 32'(busy | done), 32'd0);
        req_valid = 1'b0;
        step();
        check("b2b valid drop", 32'(rd_valid), 32'd0);

        // MFHI held valid behind a MULT must see the new product.
        req_f = F_MULT; req_a = 4'd15; req_b = 4'd15; req_valid = 1'b1;
        step();
        req_f    = F_MFHI;
        req_a    = 4'd0;
        req_b    = 4'd0;
        k        = 0;
        first_rd = -1;
        n_rd     = 0;
        rd_seen  = 4'd0;
        while (k < 12) begin
            if (rd_valid === 1'b1) begin
                n_rd++;
                if (first_rd < 0) begin
                    first_rd = k;
                    rd_seen  = rd_data;
                end
            end
            go = (req_ready === 1'b1) && req_valid;
            step();
            k++;
            if (go) req_valid = 1'b0;
        end
        check("stall read latency", first_rd, N + 3);
        check("stall read pulses", n_rd, 1);
        check("stall read data", 32'(rd_seen), 32'hE);
        check("stall out_2n", 32'(out_2n), 32'hE1);

        // Reset in the middle of a DIV.
        req_f = F_DIV; req_a = 4'd14; req_b = 4'd3; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_2n", 32'(out_2n), 32'd0);
        check("abort flags", 32'({rd_valid, done, busy}), 32'd0);
        check("abort rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("abort ready", 32'(req_ready), 32'd1);
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done === 1'b1) n_done++;
        end
        check("abort no done", n_done, 0);
        check("abort hilo", 32'(out_2n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that owns the HI/LO register pair. It sequences an iterative unsigned shift-add multiply and a restoring divide over N cycles, replacing the single-cycle combinational `*`, `/` and `%`.
- Accepts one command at a time from the execute stage through a valid/ready handshake. Commands are MULT, DIV, MTHI, MTLO, MFHI and MFLO, using the existing 4-bit F function encoding.
- Signals completion, stall and divide-by-zero back to the pipeline control.

Parameters:
n, 4, operand width in bits; HI, LO and the iteration count are all n.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command present
- req_ready  output  1  command accepted on an edge where req_valid && req_ready
- req_f  input  4  function code
- req_a  input  n  operand a (dividend or multiplicand; source for MTHI/MTLO)
- req_b  input  n  operand b (divisor or multiplier)
- rd_valid  output  1  one-cycle pulse; rd_data holds the MFHI/MFLO result
- rd_data  output  n  read result
- done  output  1  one-cycle pulse; MULT/DIV result is committed to HI/LO
- div_by_zero  output  1  sticky flag; set by a DIV with b==0, cleared by the next accepted MULT/DIV
- busy  output  1  high while an arithmetic operation is in flight
- out_2n  output  2n  {hi,lo}, for display

Behaviour:
- Reset (rst_n low, asynchronous):
  - hi, lo, rd_data := 0.
  - rd_valid, done, div_by_zero, busy := 0.
  - state := IDLE; iteration counter := 0.
  - Reset during BUSY aborts the operation with no HI/LO write.
- F decode:
  - F[3]=1, F[1]=1: MULT.
  - F[3]=1, F[1]=0: DIV.
  - F[3]=0, F[0]=1, F[1]=0: MTHI.
  - F[3]=0, F[0]=1, F[1]=1: MTLO.
  - F[3]=0, F[0]=0: read; F[1]=1 selects MFHI, F[1]=0 selects MFLO.
  - F[2] is ignored.
- States: IDLE, BUSY, DONE. req_ready = (state==IDLE).
- IDLE, on accept:
  - MTHI: hi := req_a at the accept edge; no pulse; stays in IDLE.
  - MTLO: lo := req_a at the accept edge; no pulse; stays in IDLE.
  - MFHI/MFLO: rd_data := hi or lo at the accept edge; rd_valid high for the following cycle; stays in IDLE. Back-to-back reads are accepted every cycle.
  - MULT/DIV: latch operands into internal working registers; counter := n; busy := 1; go to BUSY. req_a and req_b may change after the accept edge.
  - DIV with b==0: go to DONE directly instead of BUSY. lo := all ones, hi := a, div_by_zero := 1. done pulses one cycle after accept.
- BUSY: one iteration per cycle; counter decrements; the state after the counter reaches 0 is DONE.
  - MULT: 2n-bit accumulator, shift-add over multiplier bits LSB first; product is exact with no overflow.
  - DIV: restoring divide on an n-bit remainder with n+1-bit trial subtract, quotient bits MSB first; quotient = floor(a/b), remainder = a mod b.
  - hi/lo are not modified while BUSY.
- DONE, one cycle:
  - Commit at the edge entering DONE: MULT gives {hi,lo} := product; DIV gives lo := quotient, hi := remainder.
  - done = 1, busy = 0, req_ready = 0; next state is IDLE.
- Latency:
  - MULT/DIV accepted at edge E0 → results visible in hi/lo after edge E0+n+1; done high in cycle n+1.
  - Throughput is one op per n+2 cycles.
  - Reads have one-cycle latency.
- Stall: in BUSY or DONE, req_ready=0. A request held valid is accepted on the first IDLE edge. A MFHI/MFLO issued behind a MULT therefore returns the new result.
- req_valid with req_ready=0 has no effect, and the request is not queued internally.
- out_2n always reflects the current {hi,lo}; it is never the partial accumulator.

Test Plan:
1. n=4, MULT a=13, b=11 → req_ready low for 6 cycles. done pulses 5 cycles after accept. hi=4'h8, lo=4'hF, out_2n=8'h8F.
2. DIV a=13, b=4 → after n+1 cycles: lo=3, hi=1, div_by_zero=0. Then MFLO → rd_valid next cycle with rd_data=3.
3. DIV a=9, b=0 → done one cycle after accept; lo=4'hF, hi=9, div_by_zero=1. A following MULT 2×3 clears the flag; lo=6, hi=0.
4. MTHI a=5, then MTLO a=4'hA, then MFHI and MFLO on consecutive cycles → rd_data=5 then 4'hA, rd_valid high on two consecutive cycles. No busy, no done.
5. MULT 15×15 accepted, MFHI held valid immediately behind it → MFHI accepted only after DONE. rd_data=4'hE, and lo=1 is not read.
6. Start DIV 14/3, assert rst_n low mid-BUSY → hi, lo, busy, done, rd_valid all 0 immediately. After release req_ready=1 and no done pulse occurs.
